// File: rtl/demux7_scanner.sv
// Scans a remote 7:1 mux by stepping its select and demultiplexing the read-back bit into a 7-bit word.
// Optional free-running mode: define DEMUX7_SCANNER_CONTINUOUS_EN to rescan forever after the first start.
module demux7_scanner #(
  parameter int HOLD = 1
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       start,
  input  logic       din,
  output logic [2:0] sel,
  output logic [6:0] out,
  output logic       valid,
  output logic       busy
);

  localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;

  typedef enum logic {IDLE, SCAN} state_t;

  state_t        state_reg;
  logic [CW-1:0] hold_reg;
  logic [6:0]    shadow_reg;
  logic [6:0]    captured;

  // Shadow word with the bit currently being read folded in.
  always_comb begin
    captured = shadow_reg;
    captured[sel] = din;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_reg  <= IDLE;
      hold_reg   <= '0;
      shadow_reg <= '0;
      sel        <= 3'd0;
      out        <= 7'd0;
      valid      <= 1'b0;
      busy       <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state_reg)
        IDLE: begin
          sel  <= 3'd0;
          busy <= 1'b0;
          if (start) begin
            state_reg <= SCAN;
            hold_reg  <= '0;
            busy      <= 1'b1;
          end
        end
        SCAN: begin
          if (int'(hold_reg) < HOLD - 1) begin
            hold_reg <= hold_reg + 1'b1;
          end else begin
            hold_reg   <= '0;
            shadow_reg <= captured;
            if (sel < 3'd6) begin
              sel <= sel + 3'd1;
            end else begin
              // Whole word lands on out in one edge; partial scans stay hidden.
              out   <= captured;
              valid <= 1'b1;
              sel   <= 3'd0;
`ifndef DEMUX7_SCANNER_CONTINUOUS_EN
              state_reg <= IDLE;
              busy      <= 1'b0;
`endif
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
